// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: MIPS exception codes and FSM states.
package pipe_ctrl_pkg;

  localparam logic [7:0] EXC_INT  = 8'h01;
  localparam logic [7:0] EXC_ADEL = 8'h04;
  localparam logic [7:0] EXC_ADES = 8'h05;
  localparam logic [7:0] EXC_SYS  = 8'h08;
  localparam logic [7:0] EXC_BP   = 8'h09;
  localparam logic [7:0] EXC_RI   = 8'h0A;
  localparam logic [7:0] EXC_OV   = 8'h0C;
  localparam logic [7:0] EXC_TR   = 8'h0D;
  localparam logic [7:0] EXC_ERET = 8'h0E;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    WAIT_REDIR = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage stall requests and exception info in, hold mask and redirect out.
// The redirect is a valid/ready pair; redirect_valid holds until if_redirect_ready is seen.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int XLEN   = 32
);
  logic [STAGES-1:0] stallreq;
  logic [XLEN-1:0]   excepttype_i;
  logic [XLEN-1:0]   cp0_epc_i;
  logic              if_redirect_ready;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic              redirect_valid;
  logic [XLEN-1:0]   new_pc;
  logic              wdog_timeout;

  modport master (
    output stallreq, excepttype_i, cp0_epc_i, if_redirect_ready,
    input  stall, flush, redirect_valid, new_pc, wdog_timeout
  );

  modport slave (
    input  stallreq, excepttype_i, cp0_epc_i, if_redirect_ready,
    output stall, flush, redirect_valid, new_pc, wdog_timeout
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles with a sticky timeout flag.
// Flag is registered: it rises on the edge that ends the LIMIT-th consecutive stall cycle.
module pipe_ctrl_wdog #(
  parameter int               W     = 16,
  parameter logic [W-1:0]     LIMIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any_i,
  output logic timeout_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         flag_q, flag_d;

  always_comb begin
    cnt_d = '0;
    if (stall_any_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + W'(1);
    end
    flag_d = flag_q | (cnt_d == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller; stall, flush and first redirect cycle are same-cycle combinational.
// Redirect holds (pipeline fully stalled) until fetch is ready; watchdog only with PIPE_CTRL_WDOG_EN defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES     = 6,
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   EXC_VECTOR = XLEN'(32'hBFC00380),
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(16'hFFFF)
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  pc_state_e         state_q;
  logic [XLEN-1:0]   target_q;
  logic [XLEN-1:0]   target_d;
  logic              exc_vld;
  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] stall_c;
  logic              flush_c;
  logic              rv_c;
  logic [XLEN-1:0]   pc_c;

  assign exc_vld = (bus.excepttype_i != '0);

  always_comb begin
    target_d = EXC_VECTOR;
    case (bus.excepttype_i)
      XLEN'(EXC_ERET): target_d = bus.cp0_epc_i;
      XLEN'(EXC_INT), XLEN'(EXC_ADEL), XLEN'(EXC_ADES), XLEN'(EXC_SYS),
      XLEN'(EXC_BP), XLEN'(EXC_RI), XLEN'(EXC_OV), XLEN'(EXC_TR):
                       target_d = EXC_VECTOR;
      default:         target_d = EXC_VECTOR;
    endcase
  end

  // Prefix mask: once the highest requesting middle stage is found, it and everything below hold.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    stall_mask = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k >= 1 && k <= STAGES - 2 && bus.stallreq[k]) seen = 1'b1;
      stall_mask[k] = seen;
    end
  end

  always_comb begin
    stall_c = '0;
    flush_c = 1'b0;
    rv_c    = 1'b0;
    pc_c    = '0;
    if (!rst) begin
      if (exc_vld) begin
        flush_c = 1'b1;
        rv_c    = 1'b1;
        pc_c    = target_d;
      end else if (state_q == WAIT_REDIR) begin
        rv_c    = 1'b1;
        pc_c    = target_q;
        stall_c = '1;
      end else begin
        stall_c = stall_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      case (state_q)
        RUN, WAIT_REDIR: begin
          if (exc_vld) begin
            target_q <= target_d;
            state_q  <= bus.if_redirect_ready ? RUN : WAIT_REDIR;
          end else if (state_q == WAIT_REDIR && bus.if_redirect_ready) begin
            state_q  <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.stall          = stall_c;
  assign bus.flush          = flush_c;
  assign bus.redirect_valid = rv_c;
  assign bus.new_pc         = pc_c;

`ifdef PIPE_CTRL_WDOG_EN
  pipe_ctrl_wdog #(
    .W     (WDOG_W),
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stall_any_i (|stall_c),
    .timeout_o   (bus.wdog_timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg       = ^{WDOG_LIMIT, WDOG_W};
  assign bus.wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle vector table plus redirect, reset and watchdog sequences.
module tb_pipe_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(6), .XLEN(32)) bus ();

  pipe_ctrl #(
    .STAGES     (6),
    .XLEN       (32),
    .EXC_VECTOR (32'hBFC00380),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  sr;
    logic [31:0] exc;
    logic [31:0] epc;
    logic        rdy;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        e_rv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic e_rv, input logic [31:0] e_pc);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(e_flush));
    chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(e_rv));
    chk({tag, ".new_pc"}, bus.new_pc, e_pc);
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
  task automatic cyc(input logic [5:0] sr, input logic [31:0] exc, input logic [31:0] epc,
                     input logic rdy);
    @(posedge clk);
    #1;
    bus.stallreq          = sr;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
    bus.if_redirect_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{6'b011000, 32'h0,  32'h0,        1'b1, 6'b011111, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{6'b000100, 32'h0,  32'h0,        1'b1, 6'b000111, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{6'b000010, 32'h0,  32'h0,        1'b1, 6'b000011, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{6'b100001, 32'h0,  32'h0,        1'b1, 6'b000000, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{6'b111111, 32'h0,  32'h0,        1'b0, 6'b011111, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{6'b010000, 32'h8,  32'h0,        1'b1, 6'b000000, 1'b1, 1'b1, VEC};
    vecs[6] = '{6'b000000, 32'h0,  32'h0,        1'b1, 6'b000000, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{6'b001000, 32'hE,  32'h12345678, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h12345678};
    vecs[8] = '{6'b000000, 32'h33, 32'h12345678, 1'b1, 6'b000000, 1'b1, 1'b1, VEC};
    vecs[9] = '{6'b001000, 32'h0,  32'h0,        1'b1, 6'b001111, 1'b0, 1'b0, 32'h0};

    bus.stallreq          = '0;
    bus.excepttype_i      = '0;
    bus.cp0_epc_i         = '0;
    bus.if_redirect_ready = 1'b0;
    rst                   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("reset", 6'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.wdog_timeout", 32'(bus.wdog_timeout), 32'h0);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].sr, vecs[i].exc, vecs[i].epc, vecs[i].rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_rv, vecs[i].e_pc);
    end

    // ERET with fetch not ready for three cycles, stall requests ignored while waiting.
    cyc(6'b000000, 32'hE, 32'h80001234, 1'b0);
    chk_out("eret.c1", 6'b000000, 1'b1, 1'b1, 32'h80001234);
    cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    chk_out("eret.c2", 6'b111111, 1'b0, 1'b1, 32'h80001234);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk_out("eret.c3", 6'b111111, 1'b0, 1'b1, 32'h80001234);
    cyc(6'b000000, 32'h0, 32'h0, 1'b1);
    chk_out("eret.accept", 6'b111111, 1'b0, 1'b1, 32'h80001234);
    cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    chk_out("eret.run", 6'b000111, 1'b0, 1'b0, 32'h0);

    // A new exception while waiting re-flushes and replaces the latched target.
    cyc(6'b000000, 32'hE, 32'h80004444, 1'b0);
    chk_out("retgt.c1", 6'b000000, 1'b1, 1'b1, 32'h80004444);
    cyc(6'b000000, 32'hC, 32'h80004444, 1'b0);
    chk_out("retgt.ov", 6'b000000, 1'b1, 1'b1, VEC);
    cyc(6'b000000, 32'h0, 32'h80004444, 1'b0);
    chk_out("retgt.hold", 6'b111111, 1'b0, 1'b1, VEC);
    cyc(6'b000000, 32'h0, 32'h0, 1'b1);
    chk_out("retgt.accept", 6'b111111, 1'b0, 1'b1, VEC);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk_out("retgt.run", 6'b000000, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a pending redirect abandons it.
    cyc(6'b000000, 32'h9, 32'h0, 1'b0);
    chk_out("rstmid.exc", 6'b000000, 1'b1, 1'b1, VEC);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk_out("rstmid.wait", 6'b111111, 1'b0, 1'b1, VEC);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("rstmid.after", 6'b000000, 1'b0, 1'b0, 32'h0);

`ifdef PIPE_CTRL_WDOG_EN
    for (int i = 0; i < 7; i++) cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk("wdog.after7", 32'(bus.wdog_timeout), 32'h0);
    for (int i = 0; i < 7; i++) cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    chk("wdog.gap_reset", 32'(bus.wdog_timeout), 32'h0);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk("wdog.trip", 32'(bus.wdog_timeout), 32'h1);
    cyc(6'b000000, 32'h0, 32'h0, 1'b0);
    chk("wdog.sticky", 32'(bus.wdog_timeout), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wdog.rst_clear", 32'(bus.wdog_timeout), 32'h0);
`else
    for (int i = 0; i < 20; i++) cyc(6'b000100, 32'h0, 32'h0, 1'b0);
    chk("wdog.disabled", 32'(bus.wdog_timeout), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the MIPS core. It replaces the fixed 6-stage stall/flush controller. It arbitrates per-stage stall requests into a prefix stall mask and decodes exception types into a flush plus redirect target. It holds the redirect until the fetch unit accepts it, and can optionally detect a pipeline stuck in stall.

## Interface
- `STAGES`, 6, number of pipeline stages; index 0 = PC, index STAGES-1 = WB.
- `XLEN`, 32, width of the exception type, EPC and PC buses.
- `EXC_VECTOR`, 32'hBFC00380, general exception entry address.
- `WDOG_W`, 16, width of the watchdog counter.
- `WDOG_LIMIT`, 16'hFFFF, number of consecutive stall cycles that trips the watchdog.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stallreq`  in  STAGES  stall request from stage k; bits 0 and STAGES-1 are ignored.
- `excepttype_i`  in  XLEN  exception type from MEM; zero means no exception.
- `cp0_epc_i`  in  XLEN  EPC from CP0.
- `if_redirect_ready`  in  1  fetch unit accepts the redirect this cycle.
- `stall`  out  STAGES  per-stage hold mask.
- `flush`  out  1  flush all pipeline registers.
- `redirect_valid`  out  1  `new_pc` is valid and pending.
- `new_pc`  out  XLEN  redirect target.
- `wdog_timeout`  out  1  sticky stall-watchdog flag.

## Operation
**Exception decode**
- Code 0x0E (ERET) -> target = `cp0_epc_i`.
- Codes 0x01, 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C, 0x0D -> target = `EXC_VECTOR`.
- Any other nonzero code -> target = `EXC_VECTOR`.

**Stall arbitration**
- Highest k in 1..STAGES-2 with `stallreq[k]=1` -> `stall[k:0]` all 1, upper bits 0.
- No request -> `stall` = 0.

**FSM**
- States: RUN, WAIT_REDIR.
- RUN, `excepttype_i` != 0:
  - `flush`=1, `redirect_valid`=1, `new_pc`=decoded target (combinational), `stall`=0, target latched.
  - If `if_redirect_ready`=1, stay in RUN; otherwise go to WAIT_REDIR.
- RUN, no exception: apply stall arbitration; `flush`=0; `redirect_valid`=0; `new_pc`=0.
- WAIT_REDIR:
  - `flush`=0, `redirect_valid`=1, `new_pc`=latched target, `stall`=all 1, stall requests ignored.
  - `if_redirect_ready`=1 -> RUN next cycle.
- WAIT_REDIR with a new nonzero `excepttype_i`: handled exactly as in RUN. This re-flushes, retargets and overwrites the latch.
- Exception always takes priority over stall requests.

**Reset values**
- State RUN, latched target 0, watchdog counter 0.
- `stall`=0, `flush`=0, `redirect_valid`=0, `new_pc`=0, `wdog_timeout`=0.

## Timing
- Stall mask, `flush` and a first-cycle redirect are combinational from the inputs: zero latency, same cycle.
- WAIT_REDIR outputs are driven from registers.
- Redirect handshake completes in the first cycle where `redirect_valid` and `if_redirect_ready` are both 1. `redirect_valid` is low in the following cycle unless a new exception arrives.
- `flush` is exactly 1 cycle per exception event.
- `rst` asserted mid-redirect: abandon the redirect; all outputs take reset values the next cycle.

## Configuration
- Macro: `PIPE_CTRL_WDOG_EN`.
- Defined:
  - Counter increments each cycle `stall` != 0 and saturates at `WDOG_LIMIT`.
  - Counter clears on any cycle with `stall` == 0.
  - Reaching `WDOG_LIMIT` sets `wdog_timeout`, which stays 1 until `rst`.
- Undefined: no counter is instantiated and `wdog_timeout` is tied to 0.

## Structure
- Package `pipe_ctrl_pkg`:
  - Exception code constants: EXC_INT=0x01, EXC_ADEL=0x04, EXC_ADES=0x05, EXC_SYS=0x08, EXC_BP=0x09, EXC_RI=0x0A, EXC_OV=0x0C, EXC_TR=0x0D, EXC_ERET=0x0E.
  - FSM state enum.
- Sub-module `pipe_ctrl_wdog`: the saturating counter and sticky flag, instantiated only under the macro.

## Test plan
- `stallreq`=6'b011000 (EX and MEM) -> `stall`=6'b011111, `flush`=0; with only ID requesting -> `stall`=6'b000111.
- `excepttype_i`=0x08 with `stallreq`=6'b010000 and ready=1 -> in the same cycle `flush`=1, `stall`=0, `new_pc`=BFC00380, `redirect_valid`=1; next cycle all outputs 0.
- `excepttype_i`=0x0E, `cp0_epc_i`=0x80001234, ready low for 3 cycles -> `flush` for 1 cycle, then `stall`=6'b111111 and `new_pc`=0x80001234 held for 2 more cycles; ready=1 -> RUN.
- In WAIT_REDIR, exception 0x0C arrives -> `flush`=1 again and `new_pc`=BFC00380 replaces the EPC target.
- Assert `rst` during WAIT_REDIR -> next cycle `redirect_valid`=0, `new_pc`=0, `stall`=0.
- With the macro defined and `WDOG_LIMIT`=8, hold `stallreq`=6'b000100 -> `wdog_timeout`=1 after the 8th stall cycle and stays 1 after release; a gap of 1 unstalled cycle resets the count.
